flash_read_serializer: RTL and testbench

Read-path stage between the memory array's 128-bit line output and the octal I/O pins of the flash controller. On a read burst it fetches 16-byte lines from the array, serializes them one byte per `sck` cycle onto the 8-bit output bus, and toggles `ds` per byte. It keeps one line in prefetch so the burst streams with no bubbles while `cs` stays low.

---
 rtl/flash_read_serializer_if.sv | 15 +
 rtl/flash_read_serializer.sv | 180 ++++++++++++++++++
 tb/tb_flash_read_serializer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_read_serializer_if.sv
// Line-fetch bus between the read serializer (master) and the memory array (slave).
interface flash_read_serializer_if #(
    parameter int ADDR_W = 22,
    parameter int LINE_W = 128
);
    // Handshake: mem_req and mem_addr hold steady until a cycle with mem_ack high.
    // mem_data is valid only in that cycle. The master may drop mem_req without an ack.
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/flash_read_serializer.sv
// Serializes 16-byte array lines onto the octal read bus, one byte per sck, toggling ds
// per byte, with a one-line prefetch buffer so bursts stream without bubbles.
module flash_read_serializer #(
    parameter int ADDR_W = 22,
    parameter int LINE_W = 128
) (
    input  logic                    sck,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic                    stop,
    flash_read_serializer_if.master mem,
    output logic [7:0]              dout,
    output logic                    dout_oe,
    output logic                    ds,
    output logic                    busy,
    output logic [1:0]              dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_STREAM = 2'd2,
        S_STALL  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(16);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_ptr;
    logic [LINE_W-1:0] r_cur;
    logic [LINE_W-1:0] r_pre;
    logic              r_pre_valid;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_dout;
    logic              r_ds;
    logic              r_oe;

    logic [3:0]        w_ptr_d;
    logic [LINE_W-1:0] w_cur_d;
    logic [LINE_W-1:0] w_pre_d;
    logic              w_pre_valid_d;
    logic              w_req_d;
    logic [ADDR_W-1:0] w_addr_d;
    logic [7:0]        w_dout_d;
    logic              w_ds_d;
    logic              w_oe_d;
    logic [7:0]        w_byte;
    logic              w_ack;
    logic              w_last;

    // An ack only counts while our own request is outstanding.
    assign w_ack  = mem.mem_ack && r_req;
    assign w_last = (r_ptr == 4'hF);

    always_comb begin
        w_byte = '0;
        for (int k = 0; k < 16; k++) begin
            if (r_ptr == 4'(k)) w_byte = r_cur[LINE_W-1-8*k -: 8];
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next = S_FIRST;
                S_FIRST:  if (w_ack) w_next = S_STREAM;
                S_STREAM: if (w_last && !r_pre_valid && !w_ack) w_next = S_STALL;
                S_STALL:  if (w_ack) w_next = S_STREAM;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ptr_d       = r_ptr;
        w_cur_d       = r_cur;
        w_pre_d       = r_pre;
        w_pre_valid_d = r_pre_valid;
        w_req_d       = r_req;
        w_addr_d      = r_addr;
        w_dout_d      = r_dout;
        w_ds_d        = r_ds;
        w_oe_d        = r_oe;
        if (stop) begin
            w_ptr_d       = '0;
            w_pre_valid_d = 1'b0;
            w_req_d       = 1'b0;
            w_addr_d      = '0;
            w_dout_d      = '0;
            w_ds_d        = 1'b0;
            w_oe_d        = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_ptr_d  = start_addr[3:0];
                        w_addr_d = {start_addr[ADDR_W-1:4], 4'h0};
                        w_req_d  = 1'b1;
                    end
                end
                S_FIRST: begin
                    if (w_ack) begin
                        w_cur_d  = mem.mem_data;
                        w_addr_d = r_addr + LINE_STEP;
                    end
                end
                S_STREAM: begin
                    w_dout_d = w_byte;
                    w_ds_d   = ~r_ds;
                    w_oe_d   = 1'b1;
                    w_ptr_d  = r_ptr + 4'd1;
                    if (!w_last && w_ack) begin
                        w_pre_d       = mem.mem_data;
                        w_pre_valid_d = 1'b1;
                        w_req_d       = 1'b0;
                    end
                    // Line boundary: promote the prefetch, or take an ack landing right now.
                    if (w_last && r_pre_valid) begin
                        w_cur_d       = r_pre;
                        w_pre_valid_d = 1'b0;
                        w_req_d       = 1'b1;
                        w_addr_d      = r_addr + LINE_STEP;
                    end else if (w_last && w_ack) begin
                        w_cur_d  = mem.mem_data;
                        w_addr_d = r_addr + LINE_STEP;
                    end
                end
                S_STALL: begin
                    if (w_ack) begin
                        w_cur_d  = mem.mem_data;
                        w_addr_d = r_addr + LINE_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_cur       <= '0;
            r_pre       <= '0;
            r_pre_valid <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_ds        <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_d;
            r_cur       <= w_cur_d;
            r_pre       <= w_pre_d;
            r_pre_valid <= w_pre_valid_d;
            r_req       <= w_req_d;
            r_addr      <= w_addr_d;
            r_dout      <= w_dout_d;
            r_ds        <= w_ds_d;
            r_oe        <= w_oe_d;
        end
    end

    assign mem.mem_req  = r_req;
    assign mem.mem_addr = r_addr;
    assign dout         = r_dout;
    assign dout_oe      = r_oe;
    assign ds           = r_ds;
    assign busy         = (r_state != S_IDLE);
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_flash_read_serializer.sv
// Directed bench for flash_read_serializer: one task per scenario, memory model with programmable ack delay.
module tb_flash_read_serializer;
    localparam int ADDR_W = 22;
    localparam int LINE_W = 128;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_STALL  = 2'd3;

    logic              sck = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [7:0]        dout;
    logic              dout_oe;
    logic              ds;
    logic              busy;
    logic [1:0]        dbg_state;

    logic              mem_auto = 1'b1;
    int                mem_delay = 0;
    int                mem_cnt = 0;
    logic              auto_ack = 1'b0;
    logic [LINE_W-1:0] auto_data = '0;
    logic              man_ack = 1'b0;
    logic [LINE_W-1:0] man_data = '0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    flash_read_serializer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) mem_bus ();

    assign mem_bus.mem_ack  = mem_auto ? auto_ack  : man_ack;
    assign mem_bus.mem_data = mem_auto ? auto_data : man_data;

    flash_read_serializer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .sck        (sck),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
        .mem        (mem_bus),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .ds         (ds),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 sck = ~sck;

    // Line contents: 0x000100 is the reference line 00 11 22 .. FF, others derive from the address.
    function automatic logic [7:0] line_byte(input logic [ADDR_W-1:0] a, input int k);
        logic [7:0] b;
        if (a == 22'h000100) return 8'(k * 17);
        b = a[11:4] + 8'(k);
        return b ^ 8'hA5;
    endfunction

    function automatic logic [LINE_W-1:0] line_data(input logic [ADDR_W-1:0] a);
        logic [LINE_W-1:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) d[LINE_W-1-8*k -: 8] = line_byte(a, k);
        return d;
    endfunction

    // Memory responder: acks mem_delay cycles after a request becomes visible.
    always @(negedge sck) begin
        if (!mem_auto) begin
            auto_ack = 1'b0;
            mem_cnt  = 0;
        end else begin
            if (auto_ack) begin
                auto_ack = 1'b0;
                mem_cnt  = 0;
            end
            if (mem_bus.mem_req && rst_n) begin
                if (mem_cnt >= mem_delay) begin
                    auto_ack  = 1'b1;
                    auto_data = line_data(mem_bus.mem_addr);
                end else begin
                    mem_cnt++;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge sck);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge sck);
        #1;
        checks++;
        if ({dout, dout_oe, ds, busy, mem_bus.mem_req} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000", {dout, dout_oe, ds, busy, mem_bus.mem_req});
        end
        checks++;
        if (mem_bus.mem_addr !== 22'h0) begin
            errors++;
            $display("FAIL reset_mem_addr got %h want 000000", mem_bus.mem_addr);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_aligned();
        logic [7:0] exp_b;
        mem_auto = 1'b1;
        mem_delay = 0;
        start = 1'b1;
        start_addr = 22'h000100;
        step();
        start = 1'b0;
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 22'h000100 || dbg_state !== ST_FIRST) begin
            errors++;
            $display("FAIL aligned_first_req got req=%b addr=%h st=%0d want 1 000100 1",
                     mem_bus.mem_req, mem_bus.mem_addr, dbg_state);
        end
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 22'h000110 || dout_oe !== 1'b0) begin
            errors++;
            $display("FAIL aligned_prefetch_req got req=%b addr=%h oe=%b want 1 000110 0",
                     mem_bus.mem_req, mem_bus.mem_addr, dout_oe);
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(line_byte(22'h000100, i));
        for (int i = 0; i < 16; i++) exp_q.push_back(line_byte(22'h000110, i));
        for (int i = 0; i < 32; i++) begin
            step();
            exp_b = exp_q.pop_front();
            checks++;
            if (dout !== exp_b || ds !== ((i % 2) == 0) || dout_oe !== 1'b1) begin
                errors++;
                $display("FAIL aligned_byte%0d got dout=%h ds=%b oe=%b want %h %b 1",
                         i, dout, ds, dout_oe, exp_b, ((i % 2) == 0));
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({dout, dout_oe, ds, busy, mem_bus.mem_req} !== 12'h000) begin
            errors++;
            $display("FAIL aligned_stop got %h want 000", {dout, dout_oe, ds, busy, mem_bus.mem_req});
        end
        step();
    endtask

    task automatic test_unaligned();
        logic [7:0] exp_b [4];
        exp_b[0] = line_byte(22'h000100, 13);
        exp_b[1] = line_byte(22'h000100, 14);
        exp_b[2] = line_byte(22'h000100, 15);
        exp_b[3] = line_byte(22'h000110, 0);
        start = 1'b1;
        start_addr = 22'h00010D;
        step();
        start = 1'b0;
        checks++;
        if (mem_bus.mem_addr !== 22'h000100) begin
            errors++;
            $display("FAIL unaligned_mem_addr got %h want 000100", mem_bus.mem_addr);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (dout !== exp_b[i] || ds !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL unaligned_byte%0d got dout=%h ds=%b want %h %b",
                         i, dout, ds, exp_b[i], ((i % 2) == 0));
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic test_slow();
        int n;
        mem_delay = 19;
        start = 1'b1;
        start_addr = 22'h000200;
        step();
        start = 1'b0;
        n = 0;
        while (dout_oe !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (dout_oe !== 1'b1 || dout !== line_byte(22'h000200, 0)) begin
            errors++;
            $display("FAIL slow_first_byte got oe=%b dout=%h want 1 %h", dout_oe, dout, line_byte(22'h000200, 0));
        end
        for (int i = 1; i < 16; i++) begin
            step();
            checks++;
            if (dout !== line_byte(22'h000200, i) || ds !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL slow_byte%0d got dout=%h ds=%b want %h %b",
                         i, dout, ds, line_byte(22'h000200, i), ((i % 2) == 0));
            end
        end
        for (int j = 0; j < 3; j++) begin
            step();
            checks++;
            if (dbg_state !== ST_STALL || dout !== line_byte(22'h000200, 15) || ds !== 1'b0 || dout_oe !== 1'b1) begin
                errors++;
                $display("FAIL slow_stall%0d got st=%0d dout=%h ds=%b oe=%b want 3 %h 0 1",
                         j, dbg_state, dout, ds, dout_oe, line_byte(22'h000200, 15));
            end
        end
        step();
        checks++;
        if (dbg_state !== ST_STREAM || dout !== line_byte(22'h000200, 15) || ds !== 1'b0
            || mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 22'h000220) begin
            errors++;
            $display("FAIL slow_ack_edge got st=%0d dout=%h ds=%b req=%b addr=%h want 2 %h 0 1 000220",
                     dbg_state, dout, ds, mem_bus.mem_req, mem_bus.mem_addr, line_byte(22'h000200, 15));
        end
        step();
        checks++;
        if (dout !== line_byte(22'h000210, 0) || ds !== 1'b1) begin
            errors++;
            $display("FAIL slow_resume got dout=%h ds=%b want %h 1", dout, ds, line_byte(22'h000210, 0));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        mem_delay = 0;
        step();
    endtask

    task automatic test_wrap();
        start = 1'b1;
        start_addr = 22'h3FFFFE;
        step();
        start = 1'b0;
        checks++;
        if (mem_bus.mem_addr !== 22'h3FFFF0) begin
            errors++;
            $display("FAIL wrap_first_addr got %h want 3ffff0", mem_bus.mem_addr);
        end
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 22'h000000) begin
            errors++;
            $display("FAIL wrap_next_addr got req=%b addr=%h want 1 000000", mem_bus.mem_req, mem_bus.mem_addr);
        end
        step();
        checks++;
        if (dout !== line_byte(22'h3FFFF0, 14)) begin
            errors++;
            $display("FAIL wrap_byte14 got %h want %h", dout, line_byte(22'h3FFFF0, 14));
        end
        step();
        checks++;
        if (dout !== line_byte(22'h3FFFF0, 15)) begin
            errors++;
            $display("FAIL wrap_byte15 got %h want %h", dout, line_byte(22'h3FFFF0, 15));
        end
        step();
        checks++;
        if (dout !== line_byte(22'h000000, 0) || ds !== 1'b1) begin
            errors++;
            $display("FAIL wrap_line0 got dout=%h ds=%b want %h 1", dout, ds, line_byte(22'h000000, 0));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic test_stop_with_ack();
        mem_auto = 1'b0;
        start = 1'b1;
        start_addr = 22'h000100;
        step();
        start = 1'b0;
        step();
        man_ack = 1'b1;
        man_data = line_data(22'h000100);
        step();
        man_ack = 1'b0;
        step();
        step();
        stop = 1'b1;
        man_ack = 1'b1;
        man_data = line_data(22'h000110);
        step();
        stop = 1'b0;
        man_ack = 1'b0;
        checks++;
        if ({dout, dout_oe, ds, busy, mem_bus.mem_req} !== 12'h000 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL stop_outputs got %h st=%0d want 000 0", {dout, dout_oe, ds, busy, mem_bus.mem_req}, dbg_state);
        end
        step();
        start = 1'b1;
        start_addr = 22'h000300;
        step();
        start = 1'b0;
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 22'h000300) begin
            errors++;
            $display("FAIL fresh_req got req=%b addr=%h want 1 000300", mem_bus.mem_req, mem_bus.mem_addr);
        end
        man_ack = 1'b1;
        man_data = line_data(22'h000300);
        step();
        man_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (dout !== line_byte(22'h000300, i) || ds !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL fresh_byte%0d got dout=%h ds=%b want %h %b",
                         i, dout, ds, line_byte(22'h000300, i), ((i % 2) == 0));
            end
        end
        checks++;
        if (dbg_state !== ST_STALL || mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 22'h000310) begin
            errors++;
            $display("FAIL fresh_stall got st=%0d req=%b addr=%h want 3 1 000310",
                     dbg_state, mem_bus.mem_req, mem_bus.mem_addr);
        end
    endtask

    task automatic test_reset_in_stall();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout, dout_oe, ds, busy, mem_bus.mem_req} !== 12'h000 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL async_reset got %h st=%0d want 000 0", {dout, dout_oe, ds, busy, mem_bus.mem_req}, dbg_state);
        end
        step();
        rst_n = 1'b1;
        mem_auto = 1'b1;
        step();
    endtask

    task automatic test_collisions();
        start = 1'b1;
        stop = 1'b1;
        start_addr = 22'h000100;
        step();
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_bus.mem_req !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL start_stop got busy=%b req=%b st=%0d want 0 0 0", busy, mem_bus.mem_req, dbg_state);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        start_addr = 22'h0003F0;
        step();
        start = 1'b0;
        checks++;
        if (dout !== line_byte(22'h000100, 1) || mem_bus.mem_addr !== 22'h000110 || dbg_state !== ST_STREAM) begin
            errors++;
            $display("FAIL start_busy got dout=%h addr=%h st=%0d want %h 000110 2",
                     dout, mem_bus.mem_addr, dbg_state, line_byte(22'h000100, 1));
        end
        step();
        checks++;
        if (dout !== line_byte(22'h000100, 2)) begin
            errors++;
            $display("FAIL start_busy_next got %h want %h", dout, line_byte(22'h000100, 2));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_slow();
        test_wrap();
        test_stop_with_ack();
        test_reset_in_stall();
        test_collisions();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
